adder_response_checker: RTL and testbench
=========================================

// Module: adder_response_checker
// PURPOSE
//  Synthesizable response checker for the full-adder datapath, sitting at the DUT outputs
//  opposite the stimulus generator. Per accepted vector: samples a/b/ci and DUT sum/cout,
//  computes the golden result, and counts vectors and mismatches. Tracks coverage of the
//  8 (a[0],b[0],ci) combinations, then reports done/pass after N_VECTORS vectors.
// PARAMETERS
//  WIDTH      1   operand width in bits; golden = a + b + ci, WIDTH+1 bits
//  N_VECTORS  8   vectors accepted per run before DONE; must be >= 1 and < 2**CNT_W
//  CNT_W      16  width of vec_cnt, err_cnt, first_err_idx
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous reset, active-low
//  start          in   1      1-cycle pulse: begin a run (IDLE or DONE only)
//  in_valid       in   1      a/b/ci/sum/cout hold a valid vector this cycle
//  a, b           in   WIDTH  DUT operands
//  ci             in   1      DUT carry-in
//  sum            in   WIDTH  DUT sum
//  cout           in   1      DUT carry-out
//  busy           out  1      high in RUN
//  done           out  1      high in DONE (level)
//  pass           out  1      done && err_cnt==0 && cov_map==8'hFF
//  vec_cnt        out  CNT_W  vectors accepted this run
//  err_cnt        out  CNT_W  mismatching vectors this run, saturating
//  first_err_idx  out  CNT_W  vec_cnt value of the first mismatching vector
//  cov_map        out  8      bit {a[0],b[0],ci} set once that combination is seen
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE; all outputs 0. This applies mid-run too; no partial results survive.
//  - FSM IDLE -start-> RUN; RUN -(accept while vec_cnt==N_VECTORS-1)-> DONE; DONE -start-> RUN.
//  - Entering RUN clears vec_cnt, err_cnt, first_err_idx, and cov_map in the same edge.
//  - start is ignored in RUN. in_valid is ignored in IDLE and DONE.
//  - Accept = RUN && in_valid. There is at most one accept per cycle, with no backpressure.
//  - A gap (in_valid==0) holds all state.
//  - On accept, compute exp = {1'b0,a}+{1'b0,b}+ci (WIDTH+1 bits) and compare against {cout,sum}.
//  - Mismatch: err_cnt+1, saturating at 2**CNT_W-1. If err_cnt==0 before this vector,
//    first_err_idx <= current vec_cnt (0-based index).
//  - On every accept: vec_cnt+1, and cov_map[{a[0],b[0],ci}] <= 1.
//  - Latency: all counters, cov_map and state reflect an accepted vector one cycle after its edge.
//  - The last vector's results and done rise on the same cycle. pass is combinational from registered state.
//  - Inputs with X/Z on an accepted cycle count as a mismatch; the bench must not rely on this.
// CONFIGURATION
//  STICKY_ERR_HALT_EN defined: the first mismatch moves RUN->DONE on that edge, with
//    vec_cnt including the failing vector. err_cnt is then 1 and pass is 0.
//  Not defined: the run always consumes exactly N_VECTORS accepts, whatever the mismatches.
// TESTING
//  1 WIDTH=1: start, 8 exhaustive vectors (a,b,ci)=0..7 with a correct DUT
//    -> done=1 one cycle after the 8th, vec_cnt=8, err_cnt=0, cov_map=8'hFF, pass=1.
//  2 Same run, sum inverted on vector index 5 only
//    -> err_cnt=1, first_err_idx=5, pass=0, done=1 after the 8th vector.
//  3 8 correct vectors with {a,b,ci}=3'b111 never applied (3'b000 sent twice)
//    -> cov_map=8'h7F, err_cnt=0, pass=0.
//  4 in_valid toggled 1/0 each cycle, plus start pulsed during RUN
//    -> start ignored, vec_cnt advances only on valid cycles, done after the 8th valid.
//  5 rst_n low for 1 cycle after 4 vectors -> IDLE, all outputs 0;
//    a new start plus 8 correct vectors -> pass=1.
//  6 WIDTH=4: a=4'hF, b=4'h1, ci=1, DUT {cout,sum}={1,4'h1} -> no error.
//    With STICKY_ERR_HALT_EN and a bad result on vector 2 -> done with vec_cnt=3, first_err_idx=2.

Source files
------------

// File: rtl/adder_response_checker.sv
// Response checker for a WIDTH-bit full-adder datapath: golden compare, error/coverage tracking, done/pass report.
// Optional macro STICKY_ERR_HALT_EN: the first mismatch ends the run immediately.
module adder_response_checker #(
  parameter int WIDTH     = 1,
  parameter int N_VECTORS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [7:0]       cov_map
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [7:0]       r_cov_map;

  logic [WIDTH:0]   w_exp;
  logic [WIDTH:0]   w_got;
  logic             w_mismatch;
  logic             w_accept;
  logic             w_last;
  logic             w_halt;
  logic [2:0]       w_cov_idx;
  logic [CNT_W-1:0] w_err_inc;

  assign w_exp     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign w_got     = {cout, sum};
  // Case inequality so X/Z on an accepted vector is flagged rather than silently passing.
  assign w_mismatch = (w_exp !== w_got);
  assign w_accept  = (r_state == S_RUN) && in_valid;
  assign w_last    = (r_vec_cnt == CNT_W'(N_VECTORS - 1));
  assign w_cov_idx = {a[0], b[0], ci};
  assign w_err_inc = (r_err_cnt == {CNT_W{1'b1}}) ? r_err_cnt : r_err_cnt + 1'b1;

`ifdef STICKY_ERR_HALT_EN
  assign w_halt = w_last || w_mismatch;
`else
  assign w_halt = w_last;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_vec_cnt       <= '0;
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
      r_cov_map       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_RUN;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_vec_cnt       <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_cov_map       <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_vec_cnt            <= r_vec_cnt + 1'b1;
            r_cov_map[w_cov_idx] <= 1'b1;
            if (w_mismatch) begin
              r_err_cnt <= w_err_inc;
              if (r_err_cnt == '0) begin
                r_first_err_idx <= r_vec_cnt;
              end
            end
            if (w_halt) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_done && (r_err_cnt == '0) && (r_cov_map == 8'hFF);
  assign vec_cnt       = r_vec_cnt;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_err_idx;
  assign cov_map       = r_cov_map;

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed, table-driven bench for adder_response_checker (WIDTH=1 and WIDTH=4 instances).
module tb_adder_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=1 instance
  logic        start1, v1, a1, b1, ci1, sum1, cout1;
  logic        busy1, done1, pass1;
  logic [15:0] vec1, err1, fe1;
  logic [7:0]  cov1;

  // WIDTH=4 instance
  logic        start4, v4, ci4, cout4;
  logic [3:0]  a4, b4, sum4;
  logic        busy4, done4, pass4;
  logic [15:0] vec4, err4, fe4;
  logic [7:0]  cov4;

  adder_response_checker #(.WIDTH(1), .N_VECTORS(8), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(v1),
    .a(a1), .b(b1), .ci(ci1), .sum(sum1), .cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_cnt(vec1), .err_cnt(err1), .first_err_idx(fe1), .cov_map(cov1)
  );

  adder_response_checker #(.WIDTH(4), .N_VECTORS(8), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(v4),
    .a(a4), .b(b4), .ci(ci4), .sum(sum4), .cout(cout4),
    .busy(busy4), .done(done4), .pass(pass4),
    .vec_cnt(vec4), .err_cnt(err4), .first_err_idx(fe4), .cov_map(cov4)
  );

  typedef struct {
    logic       a, b, ci, sum, cout;
    logic [7:0] exp_cov;
  } vec1_t;

  typedef struct {
    logic [3:0] a, b;
    logic       ci;
    logic [3:0] sum;
    logic       cout;
  } vec4_t;

  vec1_t tbl1[8];
  vec4_t tbl4[8];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send1(input logic a, input logic b, input logic ci, input logic s, input logic co);
    a1 = a; b1 = b; ci1 = ci; sum1 = s; cout1 = co; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] s, input logic co);
    a4 = a; b4 = b; ci4 = ci; sum4 = s; cout4 = co; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic send_good1(input int i);
    send1(tbl1[i].a, tbl1[i].b, tbl1[i].ci, tbl1[i].sum, tbl1[i].cout);
  endtask

  task automatic check_zero1(input string tag);
    check({tag, " busy"}, busy1, 0);
    check({tag, " done"}, done1, 0);
    check({tag, " pass"}, pass1, 0);
    check({tag, " vec_cnt"}, vec1, 0);
    check({tag, " err_cnt"}, err1, 0);
    check({tag, " first_err_idx"}, fe1, 0);
    check({tag, " cov_map"}, cov1, 0);
  endtask

  initial begin
    // Exhaustive full-adder truth table: {a,b,ci} = index.
    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1F};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3F};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF};

    tbl4[0] = '{4'hF, 4'h1, 1'b1, 4'h1, 1'b1};
    tbl4[1] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl4[2] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
    tbl4[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
    tbl4[4] = '{4'h5, 4'hA, 1'b1, 4'h0, 1'b1};
    tbl4[5] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    tbl4[6] = '{4'h3, 4'h4, 1'b1, 4'h8, 1'b0};
    tbl4[7] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0};

    rst_n = 1'b0;
    start1 = 0; v1 = 0; a1 = 0; b1 = 0; ci1 = 0; sum1 = 0; cout1 = 0;
    start4 = 0; v4 = 0; a4 = 0; b4 = 0; ci4 = 0; sum4 = 0; cout4 = 0;
    repeat (2) @(negedge clk);
    check_zero1("reset");
    check("reset dut4 busy", busy4, 0);
    check("reset dut4 vec_cnt", vec4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid in IDLE is ignored
    send1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle vec_cnt", vec1, 0);
    check("idle err_cnt", err1, 0);
    check("idle busy", busy1, 0);

    // Test 1: exhaustive correct run
    pulse_start1();
    check("t1 busy", busy1, 1);
    for (int i = 0; i < 8; i++) begin
      send_good1(i);
      check($sformatf("t1 v%0d vec_cnt", i), vec1, i + 1);
      check($sformatf("t1 v%0d cov_map", i), cov1, tbl1[i].exp_cov);
      check($sformatf("t1 v%0d err_cnt", i), err1, 0);
      check($sformatf("t1 v%0d done", i), done1, (i == 7) ? 1 : 0);
    end
    check("t1 pass", pass1, 1);
    check("t1 busy end", busy1, 0);
    send_good1(0);
    check("t1 post-done vec_cnt", vec1, 8);

    // Test 2: sum inverted on index 5
    pulse_start1();
    check("t2 restart vec_cnt", vec1, 0);
    check("t2 restart cov_map", cov1, 0);
    check("t2 restart done", done1, 0);
    for (int i = 0; i < 8; i++) begin
      send1(tbl1[i].a, tbl1[i].b, tbl1[i].ci, tbl1[i].sum ^ (i == 5), tbl1[i].cout);
      check($sformatf("t2 v%0d err_cnt", i), err1, (i >= 5) ? 1 : 0);
    end
    check("t2 first_err_idx", fe1, 5);
    check("t2 done", done1, 1);
    check("t2 pass", pass1, 0);
    check("t2 vec_cnt", vec1, 8);

    // Test 3: combination 111 never sent
    pulse_start1();
    check("t3 restart err_cnt", err1, 0);
    check("t3 restart first_err_idx", fe1, 0);
    for (int i = 0; i < 8; i++) send_good1((i == 7) ? 0 : i);
    check("t3 cov_map", cov1, 8'h7F);
    check("t3 err_cnt", err1, 0);
    check("t3 done", done1, 1);
    check("t3 pass", pass1, 0);

    // Test 4: gaps between valids, start pulsed in each gap
    pulse_start1();
    for (int i = 0; i < 8; i++) begin
      send_good1(i);
      check($sformatf("t4 v%0d vec_cnt", i), vec1, i + 1);
      if (i < 7) begin
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check($sformatf("t4 gap%0d vec_cnt", i), vec1, i + 1);
        check($sformatf("t4 gap%0d cov_map", i), cov1, tbl1[i].exp_cov);
        check($sformatf("t4 gap%0d busy", i), busy1, 1);
        check($sformatf("t4 gap%0d done", i), done1, 0);
      end
    end
    check("t4 done", done1, 1);
    check("t4 pass", pass1, 1);

    // Test 5: reset mid-run, then a clean run
    pulse_start1();
    send1(tbl1[3].a, tbl1[3].b, tbl1[3].ci, ~tbl1[3].sum, tbl1[3].cout);
    for (int i = 1; i < 4; i++) send_good1(i);
    check("t5 pre-reset vec_cnt", vec1, 4);
    check("t5 pre-reset err_cnt", err1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero1("t5 after reset");
    pulse_start1();
    for (int i = 0; i < 8; i++) send_good1(i);
    check("t5 vec_cnt", vec1, 8);
    check("t5 pass", pass1, 1);

    // Test 6: WIDTH=4 with a bad result on vector 2
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    send4(tbl4[0].a, tbl4[0].b, tbl4[0].ci, tbl4[0].sum, tbl4[0].cout);
    check("t6 v0 err_cnt", err4, 0);
    check("t6 v0 vec_cnt", vec4, 1);
    for (int i = 1; i < 8; i++) begin
      send4(tbl4[i].a, tbl4[i].b, tbl4[i].ci, (i == 2) ? 4'hE : tbl4[i].sum, tbl4[i].cout);
    end
`ifdef STICKY_ERR_HALT_EN
    check("t6 vec_cnt", vec4, 3);
`else
    check("t6 vec_cnt", vec4, 8);
`endif
    check("t6 err_cnt", err4, 1);
    check("t6 first_err_idx", fe4, 2);
    check("t6 done", done4, 1);
    check("t6 pass", pass4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
